// File: rtl/hex_display_arbiter_pkg.sv
// Shared constants for the hex display arbiter: FSM encoding, owner codes,
// blank masks and the grant-selection helper.
package hex_display_arbiter_pkg;

    localparam int TMR_W = 26;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_KB   = 2'b01;
    localparam logic [1:0] OWN_SYS  = 2'b10;

    localparam logic [5:0] BLANK_ALL = 6'b111111;
    localparam logic [5:0] BLANK_KB  = 6'b111100;
    localparam logic [5:0] BLANK_SYS = 6'b110000;

    // Round-robin: on a tie the source that was not granted last wins.
    function automatic logic pick_kb(input logic kb_p, input logic sys_p, input logic last_kb);
        return kb_p && (!sys_p || !last_kb);
    endfunction

endpackage

// File: rtl/hex_hold_timer.sv
// Loadable down-counter with a zero flag; load has priority over decrement
// and the count saturates at zero.
module hex_hold_timer #(
    parameter int WIDTH = 26
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/hex_display_arbiter.sv
// Arbitrates the six-digit hex display between the keyboard and status sources.
// Optional keyboard-digit blink is enabled by defining HEX_BLINK_EN.
//
// state | meaning
// IDLE  | nothing pending, display retained
// GRANT | one cycle: ack the selected source and load its data
// HOLD  | owner keeps the display until the hold timer reaches zero
module hex_display_arbiter
    import hex_display_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        kb_req,
    input  logic [7:0]  kb_code,
    input  logic        sys_req,
    input  logic [15:0] sys_code,
    output logic        kb_ack,
    output logic        sys_ack,
    output logic [23:0] digits,
    output logic [5:0]  blank,
    output logic [1:0]  owner
);

    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

    logic [1:0]  state_q,    state_d;
    logic        kb_pend_q,  kb_pend_d;
    logic [7:0]  kb_data_q,  kb_data_d;
    logic        sys_pend_q, sys_pend_d;
    logic [15:0] sys_data_q, sys_data_d;
    logic        last_kb_q,  last_kb_d;
    logic        sel_kb_q,   sel_kb_d;
    logic        kb_ack_q,   kb_ack_d;
    logic        sys_ack_q,  sys_ack_d;
    logic [23:0] digits_q,   digits_d;
    logic [5:0]  blank_q,    blank_d;
    logic [1:0]  owner_q,    owner_d;

    logic hold_load;
    logic hold_dec;
    logic hold_zero;
    logic start_grant;
    logic blink_toggle;

    hex_hold_timer #(.WIDTH(TMR_W)) u_hold_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .dec      (hold_dec),
        .zero     (hold_zero)
    );

`ifdef HEX_BLINK_EN
    localparam logic [TMR_W-1:0] BLINK_LOAD = TMR_W'(BLINK_DIV - 1);

    logic blink_zero;
    logic blink_load;

    // A display load in GRANT always wins over a toggle in the same cycle.
    assign blink_toggle = (owner_q == OWN_KB) && blink_zero && (state_q != ST_GRANT);
    assign blink_load   = ((state_q == ST_GRANT) && sel_kb_q) || blink_toggle;

    hex_hold_timer #(.WIDTH(TMR_W)) u_blink_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (blink_load),
        .load_val (BLINK_LOAD),
        .dec      (owner_q == OWN_KB),
        .zero     (blink_zero)
    );
`else
    assign blink_toggle = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        kb_pend_d   = kb_pend_q;
        kb_data_d   = kb_data_q;
        sys_pend_d  = sys_pend_q;
        sys_data_d  = sys_data_q;
        last_kb_d   = last_kb_q;
        sel_kb_d    = sel_kb_q;
        kb_ack_d    = 1'b0;
        sys_ack_d   = 1'b0;
        digits_d    = digits_q;
        blank_d     = blank_q;
        owner_d     = owner_q;
        hold_load   = 1'b0;
        hold_dec    = 1'b0;
        start_grant = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_grant = kb_pend_q || sys_pend_q;
            end
            ST_GRANT: begin
                // Timer was loaded on entry, so GRANT counts as the first held cycle.
                hold_dec = 1'b1;
                state_d  = ST_HOLD;
                if (sel_kb_q) begin
                    digits_d  = {16'h0000, kb_data_q};
                    blank_d   = BLANK_KB;
                    owner_d   = OWN_KB;
                    kb_pend_d = 1'b0;
                end else begin
                    digits_d   = {8'h00, sys_data_q};
                    blank_d    = BLANK_SYS;
                    owner_d    = OWN_SYS;
                    sys_pend_d = 1'b0;
                end
            end
            ST_HOLD: begin
                hold_dec = 1'b1;
                if (hold_zero) begin
                    state_d     = ST_IDLE;
                    start_grant = kb_pend_q || sys_pend_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_grant) begin
            state_d   = ST_GRANT;
            sel_kb_d  = pick_kb(kb_pend_q, sys_pend_q, last_kb_q);
            kb_ack_d  = sel_kb_d;
            sys_ack_d = !sel_kb_d;
            last_kb_d = sel_kb_d;
            hold_load = 1'b1;
        end

        if (blink_toggle) begin
            blank_d[1:0] = ~blank_q[1:0];
        end

        // New requests are applied last so they survive a same-cycle clear.
        if (kb_req) begin
            kb_pend_d = 1'b1;
            kb_data_d = kb_code;
        end
        if (sys_req) begin
            sys_pend_d = 1'b1;
            sys_data_d = sys_code;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            kb_pend_q  <= 1'b0;
            kb_data_q  <= '0;
            sys_pend_q <= 1'b0;
            sys_data_q <= '0;
            last_kb_q  <= 1'b0;
            sel_kb_q   <= 1'b0;
            kb_ack_q   <= 1'b0;
            sys_ack_q  <= 1'b0;
            digits_q   <= '0;
            blank_q    <= BLANK_ALL;
            owner_q    <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            kb_pend_q  <= kb_pend_d;
            kb_data_q  <= kb_data_d;
            sys_pend_q <= sys_pend_d;
            sys_data_q <= sys_data_d;
            last_kb_q  <= last_kb_d;
            sel_kb_q   <= sel_kb_d;
            kb_ack_q   <= kb_ack_d;
            sys_ack_q  <= sys_ack_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            owner_q    <= owner_d;
        end
    end

    assign kb_ack  = kb_ack_q;
    assign sys_ack = sys_ack_q;
    assign digits  = digits_q;
    assign blank   = blank_q;
    assign owner   = owner_q;

endmodule
